// File: rtl/audio_ch_mixer.sv
// -----------------------------------------------------------------------------
// audio_ch_mixer
//
// N-channel audio sample mixer. A frame of CH signed samples is captured on an
// in_vld strobe together with a per-channel unsigned gain and a mute mask. The
// channels are summed one multiply-accumulate per clock, the sum is scaled back
// by the unity gain (arithmetic shift, floor rounding) and saturated to
// DATA_WIDTH bits. The result is offered on a valid/ready handshake.
//
// Optional build macro: AUDIO_MIX_CLIP_CNT_EN
//   When defined, adds a 16-bit saturating clip event counter (clip_cnt) and
//   its synchronous clear input (clip_clr).
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   in_vld     one-cycle frame strobe
//   in_data    CH samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gain       CH unsigned gains, channel k at [k*GAIN_WIDTH +: GAIN_WIDTH]
//   mute       bit k set removes channel k from the sum
//   out_data   mixed, saturated sample
//   out_vld    out_data valid, held until out_ready
//   out_ready  downstream accept
//   busy       frame in progress (ACC, SAT or OUT)
//   in_drop    one-cycle pulse when a frame strobe was rejected
//   clip       one-cycle pulse alongside the out_vld rising edge on saturation
//   clip_cnt   (optional) saturating count of clip events
//   clip_clr   (optional) zeroes clip_cnt on the next edge, wins over clip
// -----------------------------------------------------------------------------
module audio_ch_mixer #(
    parameter int CH         = 4,
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [CH*DATA_WIDTH-1:0]   in_data,
    input  logic [CH*GAIN_WIDTH-1:0]   gain,
    input  logic [CH-1:0]              mute,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_vld,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       in_drop,
    output logic                       clip
`ifdef AUDIO_MIX_CLIP_CNT_EN
    ,
    output logic [15:0]                clip_cnt,
    input  logic                       clip_clr
`endif
);

    localparam int DW = DATA_WIDTH;
    localparam int GW = GAIN_WIDTH;
    localparam int PW = DW + GW + 1;         // signed product width
    localparam int IW = $clog2(CH);          // channel index width
    localparam int AW = PW + IW;             // accumulator width, no overflow over CH terms

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;

    state_t                 state_reg;
    logic signed [AW-1:0]   acc_reg;
    logic [IW-1:0]          idx_reg;
    logic [DW-1:0]          out_data_reg;
    logic                   out_vld_reg;
    logic                   in_drop_reg;
    logic                   clip_reg;

    // Unpacked view of the input bus and the captured frame.
    logic signed [DW-1:0]   in_ch    [CH];
    logic [GW-1:0]          gain_ch  [CH];
    logic signed [DW-1:0]   data_reg [CH];
    logic [GW-1:0]          gain_reg [CH];
    logic [CH-1:0]          mute_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_unpack
            assign in_ch[gi]   = in_data[gi*DW +: DW];
            assign gain_ch[gi] = gain[gi*GW +: GW];
        end
    endgenerate

    // A new frame is taken from IDLE, or from OUT in the same cycle the held
    // result is accepted (back-to-back operation).
    logic accept;
    assign accept = in_vld && ((state_reg == IDLE) || ((state_reg == OUT) && out_ready));

    // Frame capture: later changes on the input bus do not disturb the mix.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_reg <= in_ch;
            gain_reg <= gain_ch;
            mute_reg <= mute;
        end
    end

    // Single shared multiply-accumulate datapath.
    logic signed [DW-1:0]   samp_sel;
    logic [GW-1:0]          gain_sel;
    logic signed [PW-1:0]   samp_ext;
    logic signed [PW-1:0]   gain_ext;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   term;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   shifted;
    logic [DW-1:0]          sat_next;
    logic                   clip_next;

    always_comb begin
        samp_sel = data_reg[idx_reg];
        gain_sel = gain_reg[idx_reg];
        samp_ext = {{(GW+1){samp_sel[DW-1]}}, samp_sel};
        gain_ext = {{(DW+1){1'b0}}, gain_sel};           // gain is unsigned
        prod     = samp_ext * gain_ext;
        term     = mute_reg[idx_reg] ? '0 : {{IW{prod[PW-1]}}, prod};
        acc_next = acc_reg + term;

        // Undo the unity-gain scale; >>> floors toward negative infinity.
        shifted  = acc_reg >>> (GW - 1);
        sat_next = shifted[DW-1:0];
        clip_next = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_next  = SAT_MAX[DW-1:0];
            clip_next = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_next  = SAT_MIN[DW-1:0];
            clip_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            idx_reg      <= '0;
            out_data_reg <= '0;
            out_vld_reg  <= 1'b0;
            in_drop_reg  <= 1'b0;
            clip_reg     <= 1'b0;
        end else begin
            in_drop_reg <= 1'b0;
            clip_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_vld) begin
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= ACC;
                    end
                end
                ACC: begin
                    acc_reg <= acc_next;
                    if (idx_reg == IW'(CH - 1)) begin
                        state_reg <= SAT;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                    if (in_vld) begin
                        in_drop_reg <= 1'b1;
                    end
                end
                SAT: begin
                    out_data_reg <= sat_next;
                    out_vld_reg  <= 1'b1;
                    clip_reg     <= clip_next;
                    state_reg    <= OUT;
                    if (in_vld) begin
                        in_drop_reg <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_vld_reg <= 1'b0;
                        if (in_vld) begin
                            acc_reg   <= '0;
                            idx_reg   <= '0;
                            state_reg <= ACC;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (in_vld) begin
                        in_drop_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_data = out_data_reg;
    assign out_vld  = out_vld_reg;
    assign busy     = (state_reg != IDLE);
    assign in_drop  = in_drop_reg;
    assign clip     = clip_reg;

`ifdef AUDIO_MIX_CLIP_CNT_EN
    logic [15:0] clip_cnt_reg;

    // Counts each clip pulse; a clear in the same cycle suppresses the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt_reg <= '0;
        end else if (clip_clr) begin
            clip_cnt_reg <= '0;
        end else if (clip_reg && (clip_cnt_reg != 16'hFFFF)) begin
            clip_cnt_reg <= clip_cnt_reg + 16'd1;
        end
    end

    assign clip_cnt = clip_cnt_reg;
`endif

endmodule

// File: tb/tb_audio_ch_mixer.sv
// -----------------------------------------------------------------------------
// tb_audio_ch_mixer
//
// Directed bench for audio_ch_mixer with CH=4, DATA_WIDTH=16, GAIN_WIDTH=8.
// Expected values are hand-computed: out = floor(sum(sample*gain) / 128),
// clamped to the 16-bit signed range.
// -----------------------------------------------------------------------------
module tb_audio_ch_mixer;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int GW = 8;

    logic               clk;
    logic               rst;
    logic               in_vld;
    logic [CH*DW-1:0]   in_data;
    logic [CH*GW-1:0]   gain;
    logic [CH-1:0]      mute;
    logic [DW-1:0]      out_data;
    logic               out_vld;
    logic               out_ready;
    logic               busy;
    logic               in_drop;
    logic               clip;
    logic [15:0]        clip_cnt;
    logic               clip_clr;

    int total = 0;
    int bad   = 0;

    audio_ch_mixer #(
        .CH         (CH),
        .DATA_WIDTH (DW),
        .GAIN_WIDTH (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .gain      (gain),
        .mute      (mute),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_ready (out_ready),
        .busy      (busy),
        .in_drop   (in_drop),
        .clip      (clip)
`ifdef AUDIO_MIX_CLIP_CNT_EN
        ,
        .clip_cnt  (clip_cnt),
        .clip_clr  (clip_clr)
`endif
    );

`ifndef AUDIO_MIX_CLIP_CNT_EN
    assign clip_cnt = 16'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic signed [15:0] d3, input logic signed [15:0] d2,
                             input logic signed [15:0] d1, input logic signed [15:0] d0,
                             input logic [7:0] g, input logic [3:0] m);
        in_data = {d3, d2, d1, d0};
        gain    = {4{g}};
        mute    = m;
    endtask

    // One-cycle strobe; afterwards the bus is scrambled to show capture isolation.
    task automatic strobe();
        in_vld = 1'b1;
        step();
        in_vld  = 1'b0;
        in_data = {$urandom, $urandom};
        gain    = $urandom;
        mute    = 4'($urandom);
    endtask

    // Bounded wait for out_vld; n = number of samples on which it was still low.
    task automatic wait_vld(output int n);
        n = 0;
        while (out_vld !== 1'b1 && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Full frame: strobe, check latency/result/clip, accept, check handshake.
    task automatic do_frame(input string tag,
                            input logic signed [15:0] d3, input logic signed [15:0] d2,
                            input logic signed [15:0] d1, input logic signed [15:0] d0,
                            input logic [7:0] g, input logic [3:0] m,
                            input int exp_data, input logic exp_clip);
        int n;
        set_frame(d3, d2, d1, d0, g, m);
        strobe();
        chk({tag, "_busy"}, busy, 1);
        wait_vld(n);
        chk({tag, "_latency"}, n + 1, CH + 2);
        chk({tag, "_data"}, $signed(out_data), exp_data);
        chk({tag, "_clip"}, clip, exp_clip);
        accept();
        chk({tag, "_vld_low"}, out_vld, 0);
        chk({tag, "_clip_low"}, clip, 0);
        $display("frame %s: out_data=%0d clip=%0d", tag, exp_data, exp_clip);
    endtask

    initial begin
        int n;
        logic stable;

        rst       = 1'b1;
        in_vld    = 1'b0;
        in_data   = '0;
        gain      = '0;
        mute      = '0;
        out_ready = 1'b0;
        clip_clr  = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_drop", in_drop, 0);
        chk("rst_clip", clip, 0);
        chk("rst_clip_cnt", clip_cnt, 0);
        rst = 1'b0;
        step();

        // Unity gain mix: 1000 + 2000 - 500 + 0
        do_frame("unity", 16'sd0, -16'sd500, 16'sd2000, 16'sd1000, 8'd128, 4'b0000, 2500, 1'b0);
        // Positive and negative saturation
        do_frame("sat_pos", 16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000, 8'd128, 4'b0000, 32767, 1'b1);
        do_frame("sat_neg", -16'sd30000, -16'sd30000, -16'sd30000, -16'sd30000, 8'd128, 4'b0000, -32768, 1'b1);
        // Mute ch1 (2000)
        do_frame("mute", 16'sd0, -16'sd500, 16'sd2000, 16'sd1000, 8'd128, 4'b0010, 500, 1'b0);
        // Half gain, floor rounding: 1001*64/128 = 500.5 -> 500, -500.5 -> -501
        do_frame("half_pos", 16'sd7, 16'sd7, 16'sd7, 16'sd1001, 8'd64, 4'b1110, 500, 1'b0);
        do_frame("half_neg", 16'sd7, 16'sd7, 16'sd7, -16'sd1001, 8'd64, 4'b1110, -501, 1'b0);

        // Frame strobe during ACC is dropped
        set_frame(16'sd0, -16'sd500, 16'sd2000, 16'sd1000, 8'd128, 4'b0000);
        strobe();
        set_frame(16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000, 8'd128, 4'b0000);
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        chk("drop_acc_pulse", in_drop, 1);
        step();
        chk("drop_acc_end", in_drop, 0);
        wait_vld(n);
        chk("drop_acc_vld", out_vld, 1);
        chk("drop_acc_data", $signed(out_data), 2500);
        $display("drop in ACC: result kept at 2500");

        // Backpressure: result held 10 cycles with out_ready low
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_vld !== 1'b1 || $signed(out_data) !== 2500) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        $display("backpressure: held 10 cycles");

        // Frame strobe in OUT without out_ready is dropped
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        chk("drop_out_pulse", in_drop, 1);
        chk("drop_out_vld", out_vld, 1);
        chk("drop_out_data", $signed(out_data), 2500);
        step();
        chk("drop_out_end", in_drop, 0);
        $display("drop in OUT: result kept at 2500");

        // Back-to-back: accept and new strobe in the same cycle
        set_frame(16'sd0, -16'sd500, 16'sd2000, 16'sd1000, 8'd128, 4'b0010);
        out_ready = 1'b1;
        in_vld    = 1'b1;
        step();
        out_ready = 1'b0;
        in_vld    = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_vld(n);
        chk("b2b_gap", n, CH + 1);
        chk("b2b_data", $signed(out_data), 500);
        accept();
        $display("back-to-back: gap=%0d out_data=500", n);

        // Reset mid-frame: nothing is emitted afterwards
        set_frame(16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000, 8'd128, 4'b0000);
        strobe();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_vld", out_vld, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", $signed(out_data), 0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_vld !== 1'b0 || clip !== 1'b0) stable = 1'b0;
        end
        chk("midrst_quiet", stable, 1);
        do_frame("after_rst", 16'sd100, 16'sd200, 16'sd300, 16'sd400, 8'd128, 4'b0000, 1000, 1'b0);

`ifdef AUDIO_MIX_CLIP_CNT_EN
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("cnt_cleared", clip_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            do_frame("cnt_clip", 16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000, 8'd128, 4'b0000, 32767, 1'b1);
        end
        chk("cnt_three", clip_cnt, 3);
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("cnt_clr", clip_cnt, 0);
        $display("clip counter: 3 then cleared");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
